act_lut_loader: RTL
===================

Name: act_lut_loader

Overview:
- Run-time programmable activation lookup table for the GRU/LSTM datapath. It is the writer/loader counterpart to the read-only sigmoid/tanh LUTs.
- A loader FSM accepts 2**AW table words over a valid/ready stream and writes them into internal storage.
- The block then serves lookups indexed by a raw DATA_WIDTH-bit fixed-point operand, with a 1-cycle registered read.
- Lets one instance hold a sigmoid, a tanh or a custom table, reloadable between inference passes.

Parameters:
- AW, 8, table address width; table depth = 2**AW; must equal DATA_WIDTH.
- DW, 8, table entry width (output word).
- DATA_WIDTH, 8, lookup operand width (two's-complement fixed point).
- FRACT_WIDTH, 5, fractional bits of the operand and output. Informational only; no arithmetic is performed on it.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle request to (re)load the whole table.
- wr_valid  input  1  table word valid.
- wr_data  input  DW  table word; words arrive in ascending address order 0 .. 2**AW-1.
- wr_ready  output  1  loader accepts a word this cycle.
- load_busy  output  1  high while in LOAD.
- load_done  output  1  one-cycle pulse when the last word is written.
- table_valid  output  1  a complete table is held.
- lk_valid  input  1  lookup request.
- lk_a  input  DATA_WIDTH  lookup operand; its raw bit pattern is the address (0x00 → entry 0, 0xFF/-1 → entry 255).
- lk_ready  output  1  lookup accepted this cycle.
- out_valid  output  1  result valid; one-cycle pulse per accepted lookup.
- out_y  output  DW  looked-up value.
- lk_drop  output  1  one-cycle pulse when lk_valid is high while lk_ready is low.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE, word counter=0.
  - wr_ready, load_busy, load_done, table_valid, lk_ready, out_valid, lk_drop = 0; out_y = 0.
  - Memory contents are not reset and are don't-care until a full load completes.
- FSM states: IDLE, LOAD, READY.
  - IDLE: table_valid=0. load_start → LOAD.
  - LOAD:
    - load_busy=1, wr_ready=1, table_valid=0.
    - Each cycle with wr_valid&&wr_ready writes mem[cnt]=wr_data, then cnt++.
    - Gaps in wr_valid are allowed and have unbounded length.
    - On the write with cnt==2**AW-1: next state READY, cnt wraps to 0, load_done pulses in the following cycle, table_valid=1 from the following cycle.
  - READY: table_valid=1, lk_ready=1. load_start → LOAD, with cnt=0 and table_valid cleared next cycle.
- load_start while in LOAD restarts the load: cnt←0 and previously written words are discarded logically. If load_start and a wr_valid handshake occur in the same cycle, the word is dropped and the count restarts at 0.
- In IDLE and READY, wr_ready=0 and wr_data is ignored.
- Lookup:
  - lk_ready = (state==READY) combinationally.
  - An accepted lookup in cycle N gives out_valid=1 and out_y=mem[lk_a] in cycle N+1. Latency is 1 with full throughput: back-to-back lookups produce back-to-back results.
  - out_y holds its last value when out_valid=0.
- lk_valid with lk_ready=0 (IDLE or LOAD): no result is produced and lk_drop pulses the next cycle.
- A lookup accepted in the same cycle as load_start still returns its result, read from the old table, in the next cycle.
- No read/write collision can occur: writes happen only in LOAD and reads only in READY.
- Reset mid-load: returns to IDLE with table_valid=0. A complete reload is required before lookups.

Test Plan:
- Lookup before any load: after reset, lk_valid=1, lk_a=0x10 → lk_ready=0, no out_valid, lk_drop=1 next cycle, table_valid=0.
- Full load with back-to-back words:
  - Stimulus: load_start, then 256 words wr_data=i^0x5A with wr_valid held high.
  - Required: wr_ready=1 for exactly 256 handshakes; load_done pulses once, one cycle after the 256th write; table_valid=1.
  - Then sweep lk_a=0..255 every cycle → out_y=lk_a^0x5A, each result one cycle after its lookup, no gaps.
- Stalled load: wr_valid toggles 1,0,0,1 with random gaps → count advances only on handshakes; load_done arrives after exactly 256 accepted words; a readback of all entries matches.
- Restart mid-load:
  - Stimulus: load 100 words, pulse load_start, then load 256 words wr_data=i.
  - Required: load_done pulses only once, after the second sequence; lk_a=0x63 → out_y=0x63, not the first-sequence value.
- Reload from READY with an in-flight lookup:
  - Stimulus: in READY, lk_a=0xFF and load_start in the same cycle.
  - Required: out_y=old mem[255] next cycle; table_valid=0 afterwards; lk_valid during LOAD → lk_drop.
- Reset mid-load: rst_n low after 50 words → all outputs 0 immediately; after release, state IDLE and lookups are dropped until a full 256-word load completes.

Source files
------------

// File: rtl/act_lut_loader.sv
// Run-time programmable activation lookup table: a loader FSM fills the table
// from a valid/ready word stream, then serves 1-cycle registered lookups.
module act_lut_loader #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  wr_valid,
    input  logic [DW-1:0]         wr_data,
    output logic                  wr_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  table_valid,
    input  logic                  lk_valid,
    input  logic [DATA_WIDTH-1:0] lk_a,
    output logic                  lk_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_y,
    output logic                  lk_drop
);

    // state | meaning
    // IDLE  | no table held, waiting for load_start
    // LOAD  | accepting table words in ascending address order
    // READY | complete table held, serving lookups

    generate
        if (AW != DATA_WIDTH || FRACT_WIDTH > DATA_WIDTH) begin : g_param_error
            $error("act_lut_loader: AW must equal DATA_WIDTH and FRACT_WIDTH must fit in DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mem [2**AW];
    logic          wr_fire;
    logic          lk_fire;

    // Flags decode straight from the state register so they switch with it.
    assign wr_ready    = (state == LOAD);
    assign load_busy   = (state == LOAD);
    assign table_valid = (state == READY);
    assign lk_ready    = (state == READY);

    assign wr_fire = wr_valid && wr_ready;
    assign lk_fire = lk_valid && lk_ready;

    // A word arriving together with load_start belongs to the abandoned load.
    always_ff @(posedge clk) begin
        if (wr_fire && !load_start) begin
            mem[cnt] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            load_done <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            lk_drop   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            out_valid <= lk_fire;
            lk_drop   <= lk_valid && !lk_ready;
            if (lk_fire) begin
                out_y <= mem[lk_a];
            end

            case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        cnt <= '0;
                    end else if (wr_fire) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state     <= READY;
                            load_done <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (load_start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
